// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Parametrised UART receiver with a show-ahead receive FIFO.
//   The serial input is synchronised, start bits are qualified at mid-bit
//   (false starts are dropped), and data, optional parity and stop bits are
//   sampled once per bit period. Good bytes go into the FIFO. Framing errors,
//   parity errors and overflow are reported as sticky flags.
//
// Ports
//   clk_i         system clock
//   reset_i       asynchronous, active-high reset
//   rxd_i         serial input, idle high, asynchronous to clk_i
//   rd_en_i       pop the head entry this cycle
//   rd_data_o     FIFO head (valid while rd_valid_o)
//   rd_valid_o    FIFO not empty
//   count_o       number of entries held
//   frame_err_o   sticky: a stop bit sampled 0
//   parity_err_o  sticky: parity mismatch
//   overflow_o    sticky: byte dropped because the FIFO was full
//   clr_err_i     clears all three sticky flags

module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            rxd_i,
  input  logic                            rd_en_i,
  output logic [DATA_BITS-1:0]            rd_data_o,
  output logic                            rd_valid_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o,
  output logic                            frame_err_o,
  output logic                            parity_err_o,
  output logic                            overflow_o,
  input  logic                            clr_err_i
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] HALF     = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  logic                 meta_q, rxd_s_q;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 fe_q, fe_d;
  logic                 pe_q, pe_d;
  logic                 wait_high_q, wait_high_d;
  logic                 commit, commit_fe, commit_pe;
  logic                 par_exp;

  logic                 push_q;
  logic [DATA_BITS-1:0] push_data_q;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]     count_q, count_d;
  logic                 pop, full, wr_ok;
  logic                 frame_err_q, parity_err_q, overflow_q;

  assign par_exp = (^shift_q) ^ (PARITY == 2);

  // Two-flop synchroniser; both stages reset to the idle (high) line level.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      meta_q  <= 1'b1;
      rxd_s_q <= 1'b1;
    end else begin
      meta_q  <= rxd_i;
      rxd_s_q <= meta_q;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      stop_q      <= 1'b0;
      shift_q     <= '0;
      fe_q        <= 1'b0;
      pe_q        <= 1'b0;
      wait_high_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      stop_q      <= stop_d;
      shift_q     <= shift_d;
      fe_q        <= fe_d;
      pe_q        <= pe_d;
      wait_high_q <= wait_high_d;
    end
  end

  // Frame sequencing. The start bit is re-checked at its half point; every
  // later bit is sampled a full period after the previous sample, which
  // lands near mid-bit. The final stop sample commits the frame and returns
  // to IDLE in the same cycle so a following start bit is not missed. A
  // frame that ends on a low stop bit (line break) blocks re-arming until
  // the line has been seen high again.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    stop_d      = stop_q;
    shift_d     = shift_q;
    fe_d        = fe_q;
    pe_d        = pe_q;
    wait_high_d = wait_high_q;
    commit      = 1'b0;
    commit_fe   = 1'b0;
    commit_pe   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rxd_s_q) begin
          wait_high_d = 1'b0;
        end else if (!wait_high_q) begin
          state_d = S_START;
          bit_d   = '0;
          stop_d  = 1'b0;
          fe_d    = 1'b0;
          pe_d    = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          state_d = rxd_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) begin
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PAR: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          pe_d    = (rxd_s_q != par_exp);
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d  = '0;
          stop_d = 1'b1;
          if (!rxd_s_q) begin
            fe_d = 1'b1;
          end
          if (stop_q == LAST_STOP) begin
            commit      = 1'b1;
            commit_fe   = fe_q | ~rxd_s_q;
            commit_pe   = pe_q;
            wait_high_d = ~rxd_s_q;
            state_d     = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A good byte is staged for one cycle before it is written, so the FIFO
  // occupancy changes on the edge after the commit edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      push_q      <= commit & ~commit_fe & ~commit_pe;
      push_data_q <= shift_q;
    end
  end

  assign pop   = rd_en_i & (count_q != '0);
  assign full  = (count_q == FULL_CNT);
  assign wr_ok = push_q & (~full | pop);

  // Occupancy: a simultaneous push and pop leaves the count unchanged,
  // which is what lets a full FIFO accept a byte in its pop cycle.
  always_comb begin
    count_d = count_q;
    case ({wr_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage array; its contents are meaningless after reset because the
  // pointers and count are cleared.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= push_data_q;
    end
  end

  // Pointers and count; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Sticky error flags; a set event in the clearing cycle takes priority.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_err_q  <= (frame_err_q & ~clr_err_i) | commit_fe;
      parity_err_q <= (parity_err_q & ~clr_err_i) | commit_pe;
      overflow_q   <= (overflow_q & ~clr_err_i) | (push_q & full & ~pop);
    end
  end

  assign rd_valid_o   = (count_q != '0);
  assign rd_data_o    = rd_valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o      = count_q;
  assign frame_err_o  = frame_err_q;
  assign parity_err_o = parity_err_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Directed bench for uart_rx_fifo. Four instances share one 25 MHz clock
//   and reset: the default configuration at 217 clocks per bit, even and
//   odd parity variants and a 4-deep FIFO variant at 16 clocks per bit.

module tb_uart_rx_fifo;

  localparam int CPB_MAIN = 217;
  localparam int CPB_FAST = 16;
  localparam int GAP_100US = 2500;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   lastStart = 0;
  int   checkCount = 0;
  int   failCount = 0;

  logic       rxdM = 1'b1, rdEnM = 1'b0, clrM = 1'b0;
  logic [7:0] rdDataM;
  logic       validM, feM, peM, ovM;
  logic [4:0] countM;

  logic       rxdP1 = 1'b1, rdEnP1 = 1'b0, clrP1 = 1'b0;
  logic [7:0] rdDataP1;
  logic       validP1, feP1, peP1, ovP1;
  logic [4:0] countP1;

  logic       rxdP2 = 1'b1, rdEnP2 = 1'b0, clrP2 = 1'b0;
  logic [7:0] rdDataP2;
  logic       validP2, feP2, peP2, ovP2;
  logic [4:0] countP2;

  logic       rxdF4 = 1'b1, rdEnF4 = 1'b0, clrF4 = 1'b0;
  logic [7:0] rdDataF4;
  logic       validF4, feF4, peF4, ovF4;
  logic [2:0] countF4;

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_fifo dutMain (
    .clk_i(clk), .reset_i(reset), .rxd_i(rxdM), .rd_en_i(rdEnM),
    .rd_data_o(rdDataM), .rd_valid_o(validM), .count_o(countM),
    .frame_err_o(feM), .parity_err_o(peM), .overflow_o(ovM), .clr_err_i(clrM)
  );

  uart_rx_fifo #(.CLKS_PER_BIT(CPB_FAST), .PARITY(1)) dutEven (
    .clk_i(clk), .reset_i(reset), .rxd_i(rxdP1), .rd_en_i(rdEnP1),
    .rd_data_o(rdDataP1), .rd_valid_o(validP1), .count_o(countP1),
    .frame_err_o(feP1), .parity_err_o(peP1), .overflow_o(ovP1), .clr_err_i(clrP1)
  );

  uart_rx_fifo #(.CLKS_PER_BIT(CPB_FAST), .PARITY(2)) dutOdd (
    .clk_i(clk), .reset_i(reset), .rxd_i(rxdP2), .rd_en_i(rdEnP2),
    .rd_data_o(rdDataP2), .rd_valid_o(validP2), .count_o(countP2),
    .frame_err_o(feP2), .parity_err_o(peP2), .overflow_o(ovP2), .clr_err_i(clrP2)
  );

  uart_rx_fifo #(.CLKS_PER_BIT(CPB_FAST), .FIFO_DEPTH(4)) dutSmall (
    .clk_i(clk), .reset_i(reset), .rxd_i(rxdF4), .rd_en_i(rdEnF4),
    .rd_data_o(rdDataF4), .rd_valid_o(validF4), .count_o(countF4),
    .frame_err_o(feF4), .parity_err_o(peF4), .overflow_o(ovF4), .clr_err_i(clrF4)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic driveRxd(input int dut, input logic v);
    case (dut)
      0:       rxdM  = v;
      1:       rxdP1 = v;
      2:       rxdP2 = v;
      default: rxdF4 = v;
    endcase
  endtask

  // Sends one frame, LSB first, starting at the current falling edge.
  // A parity bit is inserted when withPar is set; cutBit >= 0 abandons the
  // frame half way through that data bit.
  task automatic applyStimulus(input int dut, input logic [7:0] data,
                               input bit withPar, input logic parBit,
                               input logic stopVal, input int cutBit);
    int cpb;
    cpb = (dut == 0) ? CPB_MAIN : CPB_FAST;
    lastStart = cyc;
    driveRxd(dut, 1'b0);
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      driveRxd(dut, data[i]);
      if (i == cutBit) begin
        repeat (cpb / 2) @(negedge clk);
        return;
      end
      repeat (cpb) @(negedge clk);
    end
    if (withPar) begin
      driveRxd(dut, parBit);
      repeat (cpb) @(negedge clk);
    end
    driveRxd(dut, stopVal);
    repeat (cpb) @(negedge clk);
    driveRxd(dut, 1'b1);
  endtask

  // One-cycle pulse that lands on the edge offset+1 clocks after the start
  // bit was driven. sel 0 pulses clr_err on the main instance, sel 1 pulses
  // rd_en on the 4-deep instance.
  task automatic pulseAt(input int sel, input int offset);
    #1;
    while (cyc < lastStart + offset) @(negedge clk);
    if (sel == 0) clrM = 1'b1; else rdEnF4 = 1'b1;
    @(negedge clk);
    clrM = 1'b0;
    rdEnF4 = 1'b0;
  endtask

  task automatic popCheck(input int dut, input string tag, input logic [7:0] expected);
    if (dut == 0) begin
      checkOutput(tag, 32'(rdDataM), 32'(expected));
      rdEnM = 1'b1;
    end else begin
      checkOutput(tag, 32'(rdDataF4), 32'(expected));
      rdEnF4 = 1'b1;
    end
    @(negedge clk);
    rdEnM = 1'b0;
    rdEnF4 = 1'b0;
  endtask

  initial begin
    logic [7:0] frames [5];
    frames[0] = 8'h34; frames[1] = 8'h37; frames[2] = 8'h2A;
    frames[3] = 8'h30; frames[4] = 8'h32;

    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset valid", 32'(validM), 32'd0);
    checkOutput("reset count", 32'(countM), 32'd0);
    checkOutput("reset data", 32'(rdDataM), 32'd0);
    checkOutput("reset frame_err", 32'(feM), 32'd0);
    checkOutput("reset parity_err", 32'(peM), 32'd0);
    checkOutput("reset overflow", 32'(ovM), 32'd0);

    $display("[TB] five frames, no reads");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, frames[i], 1'b0, 1'b0, 1'b1, -1);
      repeat (GAP_100US) @(negedge clk);
    end
    checkOutput("t1 count", 32'(countM), 32'd5);
    checkOutput("t1 valid", 32'(validM), 32'd1);
    popCheck(0, "t1 pop0", 8'h34);
    popCheck(0, "t1 pop1", 8'h37);
    popCheck(0, "t1 pop2", 8'h2A);
    popCheck(0, "t1 pop3", 8'h30);
    popCheck(0, "t1 pop4", 8'h32);
    checkOutput("t1 empty valid", 32'(validM), 32'd0);
    checkOutput("t1 empty count", 32'(countM), 32'd0);
    popCheck(0, "t1 underflow data", 8'h00);
    checkOutput("t1 underflow count", 32'(countM), 32'd0);

    $display("[TB] false start");
    rxdM = 1'b0;
    repeat (50) @(negedge clk);
    rxdM = 1'b1;
    repeat (300) @(negedge clk);
    checkOutput("t2 count", 32'(countM), 32'd0);
    checkOutput("t2 frame_err", 32'(feM), 32'd0);
    checkOutput("t2 parity_err", 32'(peM), 32'd0);
    applyStimulus(0, 8'h39, 1'b0, 1'b0, 1'b1, -1);
    repeat (5) @(negedge clk);
    checkOutput("t2 count after", 32'(countM), 32'd1);
    popCheck(0, "t2 data", 8'h39);

    $display("[TB] framing error");
    applyStimulus(0, 8'h39, 1'b0, 1'b0, 1'b0, -1);
    repeat (5) @(negedge clk);
    checkOutput("t3 frame_err", 32'(feM), 32'd1);
    checkOutput("t3 count", 32'(countM), 32'd0);
    clrM = 1'b1;
    @(negedge clk);
    clrM = 1'b0;
    checkOutput("t3 cleared", 32'(feM), 32'd0);
    fork
      applyStimulus(0, 8'h39, 1'b0, 1'b0, 1'b0, -1);
      pulseAt(0, 2063);
    join
    repeat (5) @(negedge clk);
    checkOutput("t3 set wins", 32'(feM), 32'd1);
    checkOutput("t3 count2", 32'(countM), 32'd0);

    $display("[TB] parity");
    applyStimulus(1, 8'h2F, 1'b1, 1'b0, 1'b1, -1);
    repeat (5) @(negedge clk);
    checkOutput("t4 even bad pe", 32'(peP1), 32'd1);
    checkOutput("t4 even bad count", 32'(countP1), 32'd0);
    applyStimulus(1, 8'h2F, 1'b1, 1'b1, 1'b1, -1);
    repeat (5) @(negedge clk);
    checkOutput("t4 even good count", 32'(countP1), 32'd1);
    checkOutput("t4 even good data", 32'(rdDataP1), 32'h2F);
    applyStimulus(2, 8'h2F, 1'b1, 1'b1, 1'b1, -1);
    repeat (5) @(negedge clk);
    checkOutput("t4 odd bad pe", 32'(peP2), 32'd1);
    checkOutput("t4 odd bad count", 32'(countP2), 32'd0);
    applyStimulus(2, 8'h2F, 1'b1, 1'b0, 1'b1, -1);
    repeat (5) @(negedge clk);
    checkOutput("t4 odd good count", 32'(countP2), 32'd1);
    checkOutput("t4 odd good data", 32'(rdDataP2), 32'h2F);
    checkOutput("t4 odd frame_err", 32'(feP2), 32'd0);

    $display("[TB] small FIFO overflow");
    for (int v = 8'h30; v <= 8'h34; v++) begin
      applyStimulus(3, 8'(v), 1'b0, 1'b0, 1'b1, -1);
      repeat (4) @(negedge clk);
    end
    checkOutput("t5 count", 32'(countF4), 32'd4);
    checkOutput("t5 overflow", 32'(ovF4), 32'd1);
    checkOutput("t5 head", 32'(rdDataF4), 32'h30);
    clrF4 = 1'b1;
    @(negedge clk);
    clrF4 = 1'b0;
    checkOutput("t5 overflow cleared", 32'(ovF4), 32'd0);
    fork
      applyStimulus(3, 8'h35, 1'b0, 1'b0, 1'b1, -1);
      pulseAt(1, 155);
    join
    repeat (5) @(negedge clk);
    checkOutput("t5 full pop count", 32'(countF4), 32'd4);
    checkOutput("t5 full pop overflow", 32'(ovF4), 32'd0);
    popCheck(3, "t5 pop0", 8'h31);
    popCheck(3, "t5 pop1", 8'h32);
    popCheck(3, "t5 pop2", 8'h33);
    popCheck(3, "t5 pop3", 8'h35);
    checkOutput("t5 empty count", 32'(countF4), 32'd0);

    $display("[TB] reset mid-frame");
    applyStimulus(0, 8'h31, 1'b0, 1'b0, 1'b1, -1);
    repeat (5) @(negedge clk);
    checkOutput("t6 pre count", 32'(countM), 32'd1);
    applyStimulus(0, 8'h33, 1'b0, 1'b0, 1'b1, 3);
    reset = 1'b1;
    rxdM = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("t6 reset count", 32'(countM), 32'd0);
    checkOutput("t6 reset valid", 32'(validM), 32'd0);
    checkOutput("t6 reset data", 32'(rdDataM), 32'd0);
    checkOutput("t6 reset frame_err", 32'(feM), 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    applyStimulus(0, 8'h33, 1'b0, 1'b0, 1'b1, -1);
    repeat (5) @(negedge clk);
    checkOutput("t6 count", 32'(countM), 32'd1);
    checkOutput("t6 data", 32'(rdDataM), 32'h33);
    applyStimulus(0, 8'h39, 1'b0, 1'b0, 1'b1, -1);
    applyStimulus(0, 8'h39, 1'b0, 1'b0, 1'b1, -1);
    repeat (5) @(negedge clk);
    checkOutput("t6 b2b count", 32'(countM), 32'd3);
    popCheck(0, "t6 pop0", 8'h33);
    popCheck(0, "t6 pop1", 8'h39);
    popCheck(0, "t6 pop2", 8'h39);
    checkOutput("t6 final count", 32'(countM), 32'd0);
    checkOutput("t6 frame_err", 32'(feM), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
